// File: rtl/fir_pkg.sv
// fir_pkg: op codes, sequencer states and register-file indices shared by the FIR control path.
package fir_pkg;
  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_COPY   = 3'b001,
    OP_LOAD_S = 3'b010,
    OP_LOAD_C = 3'b011,
    OP_ADD    = 3'b100,
    OP_SUB    = 3'b101,
    OP_MUL    = 3'b110
  } op_t;
  typedef enum logic [3:0] {
    IDLE, LOADC, STORE, SH4, SH3, SH2, SH1,
    MUL1, MUL2, ADD2, MUL3, ADD3, MUL4, ADD4, EIDLE
  } state_t;
  localparam logic [3:0] R_ACC   = 4'd0;
  localparam logic [3:0] R_SAMP1 = 4'd1;
  localparam logic [3:0] R_SAMP2 = 4'd2;
  localparam logic [3:0] R_SAMP3 = 4'd3;
  localparam logic [3:0] R_SAMP4 = 4'd4;
  localparam logic [3:0] R_COEF0 = 4'd5;
  localparam logic [3:0] R_COEF1 = 4'd6;
  localparam logic [3:0] R_COEF2 = 4'd7;
  localparam logic [3:0] R_COEF3 = 4'd8;
  localparam logic [3:0] R_TMP_S = 4'd9;
  localparam logic [3:0] R_TMP_P = 4'd10;
endpackage

// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM sequencing coefficient loads, sample shift and the 4-tap MAC
// on an external register-file datapath.
module fir_sequencer
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       data_ready,
  input  logic       load_coeff,
  input  logic [1:0] coefficient_num,
  input  logic       overflow,
  output logic       cnt_up,
  output logic       clear,
  output logic       modwait,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       err
);
  state_t state_q, state_d;
  logic   modwait_q;
  op_t    op_c;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      modwait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      modwait_q <= !(state_d inside {IDLE, EIDLE});
    end
  end
  always_comb begin
    state_d = state_q;
    op_c    = OP_NOP;
    src1    = 4'd0;
    src2    = 4'd0;
    dest    = 4'd0;
    cnt_up  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE, EIDLE: state_d = load_coeff ? LOADC : data_ready ? STORE : state_q;
      LOADC: begin
        op_c    = OP_LOAD_C;
        dest    = R_COEF0 + {2'b00, coefficient_num};
        clear   = coefficient_num == 2'd3;
        state_d = IDLE;
      end
      // a sample withdrawn during STORE is an error and is not counted
      STORE: begin
        op_c    = OP_LOAD_S;
        dest    = R_TMP_S;
        cnt_up  = data_ready;
        state_d = data_ready ? SH4 : EIDLE;
      end
      SH4: begin
        op_c    = OP_COPY;
        src1    = R_SAMP3;
        dest    = R_SAMP4;
        state_d = SH3;
      end
      SH3: begin
        op_c    = OP_COPY;
        src1    = R_SAMP2;
        dest    = R_SAMP3;
        state_d = SH2;
      end
      SH2: begin
        op_c    = OP_COPY;
        src1    = R_SAMP1;
        dest    = R_SAMP2;
        state_d = SH1;
      end
      SH1: begin
        op_c    = OP_COPY;
        src1    = R_TMP_S;
        dest    = R_SAMP1;
        state_d = MUL1;
      end
      MUL1: begin
        op_c    = OP_MUL;
        src1    = R_SAMP1;
        src2    = R_COEF0;
        dest    = R_ACC;
        state_d = MUL2;
      end
      MUL2: begin
        op_c    = OP_MUL;
        src1    = R_SAMP2;
        src2    = R_COEF1;
        dest    = R_TMP_P;
        state_d = ADD2;
      end
      ADD2: begin
        op_c    = OP_ADD;
        src1    = R_ACC;
        src2    = R_TMP_P;
        dest    = R_ACC;
        state_d = overflow ? EIDLE : MUL3;
      end
      MUL3: begin
        op_c    = OP_MUL;
        src1    = R_SAMP3;
        src2    = R_COEF2;
        dest    = R_TMP_P;
        state_d = ADD3;
      end
      ADD3: begin
        op_c    = OP_ADD;
        src1    = R_ACC;
        src2    = R_TMP_P;
        dest    = R_ACC;
        state_d = overflow ? EIDLE : MUL4;
      end
      MUL4: begin
        op_c    = OP_MUL;
        src1    = R_SAMP4;
        src2    = R_COEF3;
        dest    = R_TMP_P;
        state_d = ADD4;
      end
      ADD4: begin
        op_c    = OP_ADD;
        src1    = R_ACC;
        src2    = R_TMP_P;
        dest    = R_ACC;
        state_d = overflow ? EIDLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign op      = op_c;
  assign modwait = modwait_q;
  assign err     = state_q == EIDLE;
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: randomized scenarios checked cycle by cycle against an expected
// datapath-command table built from the sequencer's published schedule.
module tb_fir_sequencer;
  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       data_ready = 1'b0;
  logic       load_coeff = 1'b0;
  logic [1:0] coefficient_num = 2'd0;
  logic       overflow = 1'b0;
  logic       cnt_up, clear, modwait, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;
  logic [18:0] obs, exp_v;
  int   vectors = 0;
  int   miscompares = 0;
  logic in_err = 1'b0;

  fir_sequencer dut (
    .clk(clk), .n_reset(n_reset), .data_ready(data_ready), .load_coeff(load_coeff),
    .coefficient_num(coefficient_num), .overflow(overflow), .cnt_up(cnt_up), .clear(clear),
    .modwait(modwait), .op(op), .src1(src1), .src2(src2), .dest(dest), .err(err)
  );

  always #5 clk = ~clk;
  assign obs = {op, src1, src2, dest, cnt_up, clear, modwait, err};

  // Expected {op,src1,src2,dest,cnt_up,clear,modwait,err} for cycle i (1..12) after a sample is accepted
  function automatic logic [18:0] sample_row(int i);
    logic [2:0] o;
    logic [3:0] a, b, d;
    logic c;
    int k;
    a = 4'd0; b = 4'd0; d = 4'd0; c = 1'b0;
    if (i == 1) begin o = 3'b010; d = 4'd9; c = 1'b1; end
    else if (i <= 5) begin o = 3'b001; d = 4'(6 - i); a = (i == 5) ? 4'd9 : 4'(5 - i); end
    else if (i == 6) begin o = 3'b110; a = 4'd1; b = 4'd5; d = 4'd0; end
    else if (i % 2 == 1) begin k = (i - 3) / 2; o = 3'b110; a = 4'(k); b = 4'(4 + k); d = 4'd10; end
    else begin o = 3'b100; a = 4'd0; b = 4'd10; d = 4'd0; end
    return {o, a, b, d, c, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    n_reset = 1'b0;
    data_ready = 1'($urandom); load_coeff = 1'($urandom); overflow = 1'($urandom);
    @(negedge clk); #1;
    vectors++;
    if (obs !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=%h", obs, 19'd0);
    end
    @(negedge clk);
    n_reset = 1'b1; data_ready = 1'b0; load_coeff = 1'b0; overflow = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (obs !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", obs, 19'd0);
    end
    in_err = 1'b0;
  endtask

  task automatic test_coeff(input logic [1:0] n, input logic dr);
    @(negedge clk);
    load_coeff = 1'b1; coefficient_num = n; data_ready = dr; overflow = 1'($urandom);
    #1;
    exp_v = {18'd0, in_err};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL coeff_idle n=%0d got=%h exp=%h", n, obs, exp_v);
    end
    @(negedge clk);
    load_coeff = 1'($urandom); overflow = 1'($urandom);
    #1;
    exp_v = {3'b011, 4'd0, 4'd0, 4'(5 + n), 1'b0, n == 2'd3, 1'b1, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL coeff_load n=%0d got=%h exp=%h", n, obs, exp_v);
    end
    @(negedge clk);
    load_coeff = 1'b0; data_ready = 1'b0; overflow = 1'b0;
    #1;
    vectors++;
    if (obs !== 19'd0) begin
      miscompares++;
      $display("FAIL coeff_back_idle n=%0d got=%h exp=%h", n, obs, 19'd0);
    end
    in_err = 1'b0;
  endtask

  // ovf_at: ADD cycle (8/10/12) that reports overflow, 0 for none; rst_at: cycle to reset in, 0 for none
  task automatic test_sample(input int ovf_at, input int rst_at, input logic drop);
    logic stop, was_reset;
    stop = 1'b0; was_reset = 1'b0;
    @(negedge clk);
    data_ready = 1'b1; load_coeff = 1'b0; overflow = 1'($urandom);
    #1;
    exp_v = {18'd0, in_err};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL sample_idle got=%h exp=%h", obs, exp_v);
    end
    for (int i = 1; i <= 12 && !stop; i++) begin
      @(negedge clk);
      data_ready = (i == 1) ? !drop : 1'($urandom);
      load_coeff = 1'($urandom);
      coefficient_num = 2'($urandom);
      overflow = (i == 8 || i == 10 || i == 12) ? (i == ovf_at) : 1'($urandom);
      #1;
      exp_v = sample_row(i);
      if (drop) exp_v[3] = 1'b0;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL sample_step%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == rst_at) begin
        n_reset = 1'b0;
        #1;
        vectors++;
        if (obs !== 19'd0) begin
          miscompares++;
          $display("FAIL reset_async step%0d got=%h exp=%h", i, obs, 19'd0);
        end
        @(negedge clk);
        n_reset = 1'b1; data_ready = 1'b0; load_coeff = 1'b0; overflow = 1'b0;
        #1;
        vectors++;
        if (obs !== 19'd0) begin
          miscompares++;
          $display("FAIL reset_mid_idle got=%h exp=%h", obs, 19'd0);
        end
        was_reset = 1'b1;
        stop = 1'b1;
      end
      if ((drop && i == 1) || i == ovf_at) stop = 1'b1;
    end
    if (was_reset) begin
      in_err = 1'b0;
    end else if (stop) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        data_ready = 1'b0; load_coeff = 1'b0; overflow = 1'($urandom);
        #1;
        exp_v = {18'd0, 1'b1};
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL eidle_hold%0d got=%h exp=%h", j, obs, exp_v);
        end
      end
      in_err = 1'b1;
    end else begin
      @(negedge clk);
      data_ready = 1'b0; load_coeff = 1'b0; overflow = 1'($urandom);
      #1;
      vectors++;
      if (obs !== 19'd0) begin
        miscompares++;
        $display("FAIL sample_done got=%h exp=%h", obs, 19'd0);
      end
      in_err = 1'b0;
    end
  endtask

  task automatic test_random(input int n);
    int sel;
    for (int t = 0; t < n; t++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: test_coeff(2'($urandom), 1'($urandom));
        1: test_sample(8 + 2 * int'($urandom_range(0, 2)), 0, 1'b0);
        2: test_sample(0, int'($urandom_range(1, 12)), 1'b0);
        3: test_sample(0, 0, 1'b1);
        default: test_sample(0, 0, 1'b0);
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    test_reset();
    for (int n = 0; n < 4; n++) test_coeff(2'(n), 1'b0);
    test_coeff(2'd2, 1'b0);
    test_coeff(2'd3, 1'b0);
    test_coeff(2'd1, 1'b1);
    test_sample(0, 0, 1'b0);
    test_sample(0, 0, 1'b0);
    test_sample(10, 0, 1'b0);
    test_sample(0, 0, 1'b0);
    test_sample(8, 0, 1'b0);
    test_coeff(2'd3, 1'b1);
    test_sample(12, 0, 1'b0);
    test_sample(0, 0, 1'b1);
    test_sample(0, 9, 1'b0);
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
